// File: rtl/serial_decrementer_pkg.sv
// Shared state encoding and sizing helper for the bit-serial decrementer.
package serial_decrementer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width; the +1 keeps WIDTH=1 from collapsing to a zero-width counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_decrementer_half_subtractor.sv
// Single-bit half subtractor: d = a - b, bo = borrow out.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  assign d  = a ^ b;
  assign bo = ~a & b;

endmodule

// File: rtl/serial_decrementer.sv
// Bit-serial decrementer (in_data - 1), LSB first, one half-subtractor cell.
// Optional SERIAL_DECREMENTER_SATURATE_EN clamps 0 - 1 to 0 instead of wrapping.
module serial_decrementer
  import serial_decrementer_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_borrow
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  logic [WIDTH-1:0]   r_sr;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_borrow;

  logic               w_d;
  logic               w_bo;
  logic [WIDTH-1:0]   w_sr_next;
  logic [WIDTH-1:0]   w_result;
  logic               w_last;

  half_subtractor u_hs (
    .a  (r_sr[0]),
    .b  (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  // Shift right, difference bit enters at the MSB; written as shifts so WIDTH=1 works.
  assign w_sr_next = (r_sr >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_DECREMENTER_SATURATE_EN
  assign w_result = w_bo ? '0 : w_sr_next;
`else
  assign w_result = w_sr_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sr         <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_borrow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sr       <= in_data;
            r_borrow   <= 1'b1;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_sr     <= w_sr_next;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_out_data   <= w_result;
            r_out_borrow <= w_bo;
            r_out_valid  <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_borrow = r_out_borrow;

endmodule
